// File: rtl/rv32_wb_pkg.sv
// Shared write-back definitions: register address width, default data width,
// and the {rd, data} layout of buffered long-latency results.
package rv32_wb_pkg;
  localparam int XLEN_DEF   = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {WIN_IDLE, WIN_PIPE, WIN_BUF} win_e;

  // Buffer entries are packed as {rd, data}; rd sits in the top bits.
  function automatic int entry_w(input int xlen);
    return REG_ADDR_W + xlen;
  endfunction
endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO for long-latency results; exports per-entry valid bits and
// storage so the owner can search pending destinations.
module wb_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic [W-1:0]              wdata,
  input  logic                      pop,
  output logic [W-1:0]              head,
  output logic                      empty,
  output logic                      full,
  output logic [DEPTH-1:0]          vld,
  output logic [DEPTH-1:0][W-1:0]   mem
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  // Pointers are AW bits wide, so DEPTH being a power of two gives the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      vld    <= '0;
      mem    <= '0;
    end else begin
      if (pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + 1'b1;
      end
      if (push) begin
        mem[wr_ptr] <= wdata;
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between the in-order pipeline
// and a buffer of long-latency results, with starvation forcing.
module wb_port_arbiter
  import rv32_wb_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int DEPTH      = 2,
  parameter int STARVE_LIM = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pipe_wr_en,
  input  logic [REG_ADDR_W-1:0] pipe_rd,
  input  logic [XLEN-1:0]       pipe_data,
  output logic                  pipe_stall,
  input  logic                  lu_valid,
  output logic                  lu_ready,
  input  logic [REG_ADDR_W-1:0] lu_rd,
  input  logic [XLEN-1:0]       lu_data,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  input  logic [REG_ADDR_W-1:0] qry_rs1,
  input  logic [REG_ADDR_W-1:0] qry_rs2,
  output logic                  qry_hit
);
  localparam int W  = entry_w(XLEN);
  localparam int CW = $clog2(STARVE_LIM + 1);

  logic                    pipe_req, forced, push, pop, empty, full;
  logic [W-1:0]            head;
  logic [REG_ADDR_W-1:0]   head_rd;
  logic [DEPTH-1:0]        vld, hit;
  logic [DEPTH-1:0][W-1:0] mem;
  logic [CW-1:0]           starve_cnt;
  win_e                    win;

  assign pipe_req = pipe_wr_en && (pipe_rd != '0);
  assign forced   = (starve_cnt == CW'(STARVE_LIM)) && !empty;
  assign lu_ready = rst_n && !full;
  assign push     = lu_valid && lu_ready;
  assign pop      = (win == WIN_BUF);
  assign head_rd  = head[W-1 -: REG_ADDR_W];
  assign pipe_stall = forced && pipe_req;

  wb_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({lu_rd, lu_data}),
    .pop   (pop),
    .head  (head),
    .empty (empty),
    .full  (full),
    .vld   (vld),
    .mem   (mem)
  );

  always_comb begin
    win = WIN_IDLE;
    if (!rst_n)        win = WIN_IDLE;
    else if (forced)   win = WIN_BUF;
    else if (pipe_req) win = WIN_PIPE;
    else if (!empty)   win = WIN_BUF;
  end

  // A head with rd = 0 still wins and pops, it just never raises rf_we.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    case (win)
      WIN_PIPE: begin
        rf_we    = 1'b1;
        rf_waddr = pipe_rd;
        rf_wdata = pipe_data;
      end
      WIN_BUF: begin
        rf_we    = (head_rd != '0);
        rf_waddr = head_rd;
        rf_wdata = head[XLEN-1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      starve_cnt <= '0;
    else if (win == WIN_BUF || empty)
      starve_cnt <= '0;
    else if (win == WIN_PIPE && starve_cnt != CW'(STARVE_LIM))
      starve_cnt <= starve_cnt + 1'b1;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_hit
    logic [REG_ADDR_W-1:0] ent_rd;
    assign ent_rd = mem[i][W-1 -: REG_ADDR_W];
    assign hit[i] = vld[i] && (((qry_rs1 != '0) && (ent_rd == qry_rs1)) ||
                               ((qry_rs2 != '0) && (ent_rd == qry_rs2)));
  end

  assign qry_hit = |hit;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed and random checks of wb_port_arbiter against a queue-based model
// of the arbitration rules, compared every cycle on the falling edge.
module tb_wb_port_arbiter;
  localparam int XLEN = 32, DEPTH = 2, STARVE_LIM = 4;

  logic            clk = 1'b0, rst_n = 1'b0;
  logic            pipe_wr_en = 1'b0, lu_valid = 1'b0;
  logic [4:0]      pipe_rd = '0, lu_rd = '0, qry_rs1 = '0, qry_rs2 = '0;
  logic [XLEN-1:0] pipe_data = '0, lu_data = '0;
  logic            pipe_stall, lu_ready, rf_we, qry_hit;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;

  wb_port_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH), .STARVE_LIM(STARVE_LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_wr_en(pipe_wr_en), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .pipe_stall(pipe_stall),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .qry_rs1(qry_rs1), .qry_rs2(qry_rs2), .qry_hit(qry_hit)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int qrd[$];
  logic [XLEN-1:0] qdat[$];
  int starve = 0;
  int dut_writes = 0, exp_writes = 0;
  bit e_headwin, e_pipewin, e_ready, e_stall, e_we, e_hit;
  logic [4:0] e_addr;
  logic [XLEN-1:0] e_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    qrd.delete();
    qdat.delete();
    starve = 0;
  endtask

  task automatic eval();
    bit preq, frc;
    preq = pipe_wr_en && (pipe_rd != 0);
    frc  = (starve == STARVE_LIM) && (qrd.size() > 0);
    e_headwin = rst_n && (qrd.size() > 0) && (frc || !preq);
    e_pipewin = rst_n && preq && !frc;
    e_ready   = rst_n && (qrd.size() < DEPTH);
    e_stall   = frc && preq;
    e_we = 0; e_addr = '0; e_data = '0;
    if (e_pipewin) begin
      e_we = 1; e_addr = pipe_rd; e_data = pipe_data;
    end else if (e_headwin && qrd[0] != 0) begin
      e_we = 1; e_addr = 5'(qrd[0]); e_data = qdat[0];
    end
    e_hit = 0;
    foreach (qrd[i])
      if (qrd[i] != 0 && (qrd[i] == int'(qry_rs1) || qrd[i] == int'(qry_rs2))) e_hit = 1;
  endtask

  // One clock: compare on the falling edge, advance the model on the rising edge.
  task automatic cyc();
    bit pre_empty;
    @(negedge clk);
    eval();
    chk("rf_we", {63'd0, rf_we}, {63'd0, e_we});
    if (e_we) begin
      chk("rf_waddr", {59'd0, rf_waddr}, {59'd0, e_addr});
      chk("rf_wdata", {32'd0, rf_wdata}, {32'd0, e_data});
    end
    chk("pipe_stall", {63'd0, pipe_stall}, {63'd0, e_stall});
    chk("lu_ready", {63'd0, lu_ready}, {63'd0, e_ready});
    chk("qry_hit", {63'd0, qry_hit}, {63'd0, e_hit});
    if (rf_we) dut_writes++;
    if (e_we) exp_writes++;
    @(posedge clk);
    if (!rst_n) model_clear();
    else begin
      pre_empty = (qrd.size() == 0);
      if (e_headwin) begin
        void'(qrd.pop_front());
        void'(qdat.pop_front());
      end
      if (lu_valid && e_ready) begin
        qrd.push_back(int'(lu_rd));
        qdat.push_back(lu_data);
      end
      if (e_headwin || pre_empty) starve = 0;
      else if (e_pipewin && starve < STARVE_LIM) starve++;
    end
    #1;
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_rf_we", {63'd0, rf_we}, 64'd0);
    chk("rst_lu_ready", {63'd0, lu_ready}, 64'd0);
    chk("rst_stall", {63'd0, pipe_stall}, 64'd0);
    chk("rst_qry_hit", {63'd0, qry_hit}, 64'd0);
    cyc(); cyc();
    rst_n = 1'b1;
    #1 chk("ready_after_rst", {63'd0, lu_ready}, 64'd1);

    // single LU result, idle pipeline: written the following cycle
    lu_valid = 1; lu_rd = 5; lu_data = 32'hDEADBEEF;
    #1 chk("lu_no_bypass", {63'd0, rf_we}, 64'd0);
    cyc();
    lu_valid = 0;
    #1 chk("lu_we", {63'd0, rf_we}, 64'd1);
    chk("lu_waddr", {59'd0, rf_waddr}, 64'd5);
    chk("lu_wdata", {32'd0, rf_wdata}, 64'hDEADBEEF);
    chk("lu_ready_stays", {63'd0, lu_ready}, 64'd1);
    cyc();

    // starvation forcing
    pipe_wr_en = 1; pipe_rd = 3; pipe_data = 32'h333;
    lu_valid = 1; lu_rd = 7; lu_data = 32'h777;
    cyc();
    lu_rd = 8; lu_data = 32'h888;
    cyc();
    lu_valid = 0;
    #1 chk("full_not_ready", {63'd0, lu_ready}, 64'd0);
    chk("no_stall_early", {63'd0, pipe_stall}, 64'd0);
    cyc(); cyc(); cyc();
    #1 chk("forced_stall", {63'd0, pipe_stall}, 64'd1);
    chk("forced_waddr", {59'd0, rf_waddr}, 64'd7);
    cyc();
    #1 chk("stall_one_cycle", {63'd0, pipe_stall}, 64'd0);
    chk("pipe_after_force", {59'd0, rf_waddr}, 64'd3);
    cyc(); cyc(); cyc(); cyc();
    #1 chk("forced_stall2", {63'd0, pipe_stall}, 64'd1);
    chk("forced_waddr2", {59'd0, rf_waddr}, 64'd8);
    cyc();

    // source query hits
    lu_valid = 1; lu_rd = 9; lu_data = 32'h999;
    cyc();
    lu_valid = 0; qry_rs1 = 9;
    #1 chk("qry_rs1_hit", {63'd0, qry_hit}, 64'd1);
    qry_rs1 = 0; qry_rs2 = 0;
    #1 chk("qry_zero", {63'd0, qry_hit}, 64'd0);
    cyc();
    pipe_wr_en = 0; qry_rs2 = 9;
    #1 chk("qry_pop_cycle", {63'd0, qry_hit}, 64'd1);
    chk("qry_pop_waddr", {59'd0, rf_waddr}, 64'd9);
    cyc();
    #1 chk("qry_after_write", {63'd0, qry_hit}, 64'd0);
    qry_rs2 = 0;

    // rd = 0 handling
    lu_valid = 1; lu_rd = 0; lu_data = 32'h1234;
    cyc();
    lu_valid = 0;
    #1 chk("rd0_dropped", {63'd0, rf_we}, 64'd0);
    cyc();
    pipe_wr_en = 1; pipe_rd = 3; lu_valid = 1; lu_rd = 4; lu_data = 32'h444;
    cyc();
    lu_valid = 0; pipe_rd = 0;
    #1 chk("pipe_rd0_yields", {59'd0, rf_waddr}, 64'd4);
    chk("pipe_rd0_we", {63'd0, rf_we}, 64'd1);
    cyc();

    // reset while full
    pipe_rd = 3; lu_valid = 1; lu_rd = 10; lu_data = 32'hA;
    cyc();
    lu_rd = 11; lu_data = 32'hB;
    cyc();
    lu_valid = 0; qry_rs1 = 10;
    #1 chk("full_before_rst", {63'd0, lu_ready}, 64'd0);
    rst_n = 0; model_clear();
    #1 chk("midrst_we", {63'd0, rf_we}, 64'd0);
    chk("midrst_ready", {63'd0, lu_ready}, 64'd0);
    chk("midrst_hit", {63'd0, qry_hit}, 64'd0);
    cyc(); cyc();
    rst_n = 1; pipe_wr_en = 0;
    #1 chk("rel_ready", {63'd0, lu_ready}, 64'd1);
    chk("rel_no_stale", {63'd0, rf_we}, 64'd0);
    cyc(); cyc();
    qry_rs1 = 0;

    // random traffic
    for (int n = 0; n < 10000; n++) begin
      pipe_wr_en = ($urandom_range(0, 3) != 0);
      pipe_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      pipe_data  = $urandom;
      lu_valid   = $urandom_range(0, 1) == 1;
      lu_rd      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      lu_data    = $urandom;
      qry_rs1    = 5'($urandom_range(0, 31));
      qry_rs2    = 5'($urandom_range(0, 31));
      cyc();
    end
    pipe_wr_en = 0; lu_valid = 0;
    repeat (DEPTH + 2) cyc();
    chk("total_writes", 64'(dut_writes), 64'(exp_writes));
    chk("drained_ready", {63'd0, lu_ready}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
